// File: rtl/compositor_pkg.sv
// Shared definitions for the layer compositor.
//  - Palette index layout: entries 0..NUM_LAYERS-1 are layers, then
//    background (NUM_LAYERS+BG_OFS) and hit tint (NUM_LAYERS+HIT_OFS).
//  - Reset palette colours, given at 4 bits per channel; the top scales
//    them to the configured channel width.
//  - rgb_w(): width of a packed {R,G,B} entry for a given channel width.
package compositor_pkg;

  localparam int BG_OFS  = 0;
  localparam int HIT_OFS = 1;

  // 4-bit-per-channel reset colours, {R,G,B}
  localparam logic [11:0] RST_L0  = 12'h0FF;
  localparam logic [11:0] RST_L1  = 12'hF00;
  localparam logic [11:0] RST_L2  = 12'hFFF;
  localparam logic [11:0] RST_L3  = 12'hFFF;
  localparam logic [11:0] RST_L4  = 12'h00F;
  localparam logic [11:0] RST_BG  = 12'h000;
  localparam logic [11:0] RST_HIT = 12'h444;

  function automatic int rgb_w(input int cw);
    return 3 * cw;
  endfunction

endpackage

// File: rtl/layer_priority_encoder.sv
// Priority encoder over the layer coverage bits; bit 0 wins.
//  layers : per-layer coverage
//  found  : any bit set
//  index  : index of the lowest set bit (0 when none)
module layer_priority_encoder #(
  parameter int NUM_LAYERS = 6,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] layers,
  output logic                  found,
  output logic [IDX_W-1:0]      index
);

  always_comb begin
    found = |layers;
    index = '0;
    // scan high to low so the lowest set bit is the last assignment
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (layers[i]) index = IDX_W'(i);
  end

endmodule

// File: rtl/layer_compositor.sv
// Layer compositor: two-stage pixel pipeline that picks the colour of the
// highest-priority covering layer from a frame-synchronous palette.
//  clk, reset (sync, active low)
//  pixel_tick        : pipeline enable
//  frame_start       : first pixel of a frame; palette commit / flash step
//  blank             : outside visible area -> black
//  layer_signal      : per-layer coverage, bit 0 highest priority
//  is_trigger_player : enables the hit tint when no layer covers
//  pal_wr_*          : valid/ready palette write into a one-entry buffer
//  RED/GREEN/BLUE    : registered output colour
// Optional: define LAYER_COMPOSITOR_FLASH_EN for a flashing hit tint with
// FLASH_FRAMES frames per half-period; otherwise the tint is steady.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 6,
  parameter int COLOR_W      = 4,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pixel_tick,
  input  logic                              frame_start,
  input  logic                              blank,
  input  logic [NUM_LAYERS-1:0]             layer_signal,
  input  logic                              is_trigger_player,
  input  logic                              pal_wr_valid,
  output logic                              pal_wr_ready,
  input  logic [$clog2(NUM_LAYERS+2)-1:0]   pal_wr_idx,
  input  logic [3*COLOR_W-1:0]              pal_wr_rgb,
  output logic [COLOR_W-1:0]                RED,
  output logic [COLOR_W-1:0]                GREEN,
  output logic [COLOR_W-1:0]                BLUE
);

  localparam int RGB_W   = rgb_w(COLOR_W);
  localparam int PW      = $clog2(NUM_LAYERS + 2);
  localparam int LW      = $clog2(NUM_LAYERS);
  localparam int BG_IDX  = NUM_LAYERS + BG_OFS;
  localparam int HIT_IDX = NUM_LAYERS + HIT_OFS;
  localparam logic [PW-1:0] BG_SEL  = PW'(BG_IDX);
  localparam logic [PW-1:0] HIT_SEL = PW'(HIT_IDX);

  // 4-bit channel value scaled so that 15 maps to full scale
  function automatic logic [COLOR_W-1:0] scale4(input logic [3:0] v);
    int t;
    t = int'(v) * ((1 << COLOR_W) - 1) / 15;
    return COLOR_W'(t);
  endfunction

  function automatic logic [RGB_W-1:0] rst_entry(input int i);
    logic [11:0] c;
    if (i == HIT_IDX)     c = RST_HIT;
    else if (i == BG_IDX) c = RST_BG;
    else begin
      case (i)
        0:       c = RST_L0;
        1:       c = RST_L1;
        2:       c = RST_L2;
        3:       c = RST_L3;
        4:       c = RST_L4;
        default: c = '0;
      endcase
    end
    return {scale4(c[11:8]), scale4(c[7:4]), scale4(c[3:0])};
  endfunction

  // ---------------- palette + pending write buffer ----------------
  logic [RGB_W-1:0] pal [NUM_LAYERS+2];
  logic             pend_full;
  logic [PW-1:0]    pend_idx;
  logic [RGB_W-1:0] pend_rgb;

  assign pal_wr_ready = ~pend_full;

  // Commit only when a write was already buffered before this frame_start,
  // so a write accepted alongside frame_start waits a full frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_full <= 1'b0;
      pend_idx  <= '0;
      pend_rgb  <= '0;
      for (int i = 0; i < NUM_LAYERS + 2; i++) pal[i] <= rst_entry(i);
    end else if (frame_start && pend_full) begin
      pend_full <= 1'b0;
      if (int'(pend_idx) <= HIT_IDX) pal[pend_idx] <= pend_rgb;
    end else if (pal_wr_valid && !pend_full) begin
      pend_full <= 1'b1;
      pend_idx  <= pal_wr_idx;
      pend_rgb  <= pal_wr_rgb;
    end
  end

  // ---------------- hit flash ----------------
  logic flash_phase;
`ifdef LAYER_COMPOSITOR_FLASH_EN
  localparam int FC_W = $clog2(FLASH_FRAMES + 1);
  logic [FC_W-1:0] flash_cnt;
  logic            flash_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      flash_cnt <= '0;
      flash_q   <= 1'b1;
    end else if (frame_start) begin
      if (flash_cnt == FC_W'(FLASH_FRAMES - 1)) begin
        flash_cnt <= '0;
        flash_q   <= ~flash_q;
      end else begin
        flash_cnt <= flash_cnt + FC_W'(1);
      end
    end
  end

  assign flash_phase = flash_q;
`else
  // steady tint; FLASH_FRAMES plays no part without the counter
  assign flash_phase = (FLASH_FRAMES > 0) | 1'b1;
`endif

  // ---------------- pixel pipeline ----------------
  logic                  s1_blank, s1_trig;
  logic [NUM_LAYERS-1:0] s1_layers;
  logic                  enc_found;
  logic [LW-1:0]         enc_idx;
  logic [RGB_W-1:0]      pix_c;

  layer_priority_encoder #(.NUM_LAYERS(NUM_LAYERS)) u_enc (
    .layers (s1_layers),
    .found  (enc_found),
    .index  (enc_idx)
  );

  always_comb begin
    pix_c = '0;
    if (!s1_blank) begin
      if (enc_found)                  pix_c = pal[PW'(enc_idx)];
      else if (s1_trig & flash_phase) pix_c = pal[HIT_SEL];
      else                            pix_c = pal[BG_SEL];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_blank  <= 1'b0;
      s1_trig   <= 1'b0;
      s1_layers <= '0;
      RED       <= '0;
      GREEN     <= '0;
      BLUE      <= '0;
    end else if (pixel_tick) begin
      s1_blank  <= blank;
      s1_trig   <= is_trigger_player;
      s1_layers <= layer_signal;
      {RED, GREEN, BLUE} <= pix_c;
    end
  end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 6, number of priority-ordered overlay layers (2..16).
REQ-002 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-003 SHALL have parameter FLASH_FRAMES, default 8, frames per half-period of the hit flash (1..255).
REQ-004 SHALL have port clk  in  1  system clock; the only clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port pixel_tick  in  1  pixel enable; the pipeline advances only when high.
REQ-007 SHALL have port frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-008 SHALL have port blank  in  1  outside the visible area.
REQ-009 SHALL have port layer_signal  in  NUM_LAYERS  per-layer coverage; bit 0 has highest priority.
REQ-010 SHALL have port is_trigger_player  in  1  player is in contact with a trigger object.
REQ-011 SHALL have port pal_wr_valid  in  1  palette write request.
REQ-012 SHALL have port pal_wr_ready  out  1  palette write accepted when high together with valid.
REQ-013 SHALL have port pal_wr_idx  in  clog2(NUM_LAYERS+2)  entry index: 0..NUM_LAYERS-1 layers, NUM_LAYERS background, NUM_LAYERS+1 hit tint.
REQ-014 SHALL have port pal_wr_rgb  in  3*COLOR_W  colour, ordered {R,G,B}.
REQ-015 SHALL have ports RED, GREEN, BLUE  out  COLOR_W each  registered pixel colour.

Function
REQ-016 SHALL form a 2-stage pipeline. On a pixel_tick, stage 1 registers blank, layer_signal and is_trigger_player. Stage 2 resolves colour and registers RED/GREEN/BLUE. Latency is exactly 2 pixel_ticks.
REQ-017 SHALL hold every pipeline register when pixel_tick is low.
REQ-018 SHALL output 0/0/0 when the stage-1 blank is high, whatever the layer bits.
REQ-019 SHALL otherwise output the active palette entry of the lowest-index set layer bit.
REQ-020 SHALL, when no layer bit is set, output the hit-tint entry if hit_visible is high, else the background entry.
REQ-021 SHALL set hit_visible = stage-1 is_trigger_player AND flash_phase.
REQ-022 SHALL have the palette write handshake complete on the cycle pal_wr_valid and pal_wr_ready are both high; the idx/rgb pair is then captured into a one-entry pending buffer.
REQ-023 SHALL deassert pal_wr_ready while the pending buffer is full.
REQ-024 SHALL commit the pending entry to the active palette on the next frame_start, then free the buffer, with pal_wr_ready high again the following cycle. The active palette SHALL never change mid-frame.
REQ-025 SHALL, for a write accepted on the same cycle as frame_start, commit it at the following frame_start, not the current one.
REQ-026 SHALL accept and then discard a write whose idx is greater than NUM_LAYERS+1; the buffer SHALL still be occupied until the next frame_start.
REQ-027 SHALL use a flash counter of width clog2(FLASH_FRAMES+1) that increments on frame_start. On reaching FLASH_FRAMES-1 it SHALL wrap to 0 and toggle flash_phase.

Reset
REQ-028 SHALL, while reset is low at a clk edge, clear all pipeline registers, RED/GREEN/BLUE, the flash counter and the pending buffer.
REQ-029 SHALL, in reset, set pal_wr_ready = 1 and flash_phase = 1.
REQ-030 SHALL load the active palette, in reset, as follows (COLOR_W=4 values, max scaled otherwise):
- layer0 = 0,15,15
- layer1 = 15,0,0
- layer2 = 15,15,15
- layer3 = 15,15,15
- layer4 = 0,0,15
- other layers = 0,0,0
- background = 0,0,0
- hit tint = 4,4,4
REQ-031 SHALL drop any pending write on reset mid-frame; the write is never committed.

Configuration
REQ-032 SHALL implement the flash counter only when macro LAYER_COMPOSITOR_FLASH_EN is defined, giving REQ-027 behaviour.
REQ-033 SHALL, without LAYER_COMPOSITOR_FLASH_EN, omit the counter, hold flash_phase at 1 and show a steady hit tint; FLASH_FRAMES is then ignored.

Structure
REQ-034 SHALL place the reset palette constants, the RGB struct width helper and the index encodings (BG_IDX, HIT_IDX offsets) in a shared package, compositor_pkg.
REQ-035 SHALL instantiate one sub-module, layer_priority_encoder, which is parameterised by NUM_LAYERS and outputs found plus index.

Verification
REQ-036 SHALL verify priority: NUM_LAYERS=6, blank=0, layer_signal=6'b010010, pixel_tick every cycle -> RED/GREEN/BLUE=15,0,0 two ticks later.
REQ-037 SHALL verify blank override: blank=1, layer_signal=6'b111111 -> 0,0,0 after 2 ticks. Also: pixel_tick low for 5 cycles -> outputs unchanged.
REQ-038 SHALL verify palette deferral: write idx=0 rgb=12'h0F0 mid-frame -> ready drops and layer0 stays 0,15,15. At the next frame_start the commit happens, ready returns next cycle and layer0 pixels become 0,15,0.
REQ-039 SHALL verify the same-cycle case: a write accepted with frame_start -> not visible in that frame, visible after the next frame_start.
REQ-040 SHALL verify flash (macro on, FLASH_FRAMES=2): is_trigger_player=1, no layers -> 4,4,4 for 2 frames, 0,0,0 for 2 frames, repeating. With the macro off -> steady 4,4,4.
REQ-041 SHALL verify reset mid-operation: pending write present, reset low for 1 cycle -> ready=1, outputs 0, and the pending write is never committed.
